// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//
// Memory-side responder for the direct-mapped cache's backing store. It accepts one
// single-word request at a time and services it against an internal word-addressed array.
// Requests are either line fills (reads) or write-backs (writes). The response appears a
// fixed LATENCY cycles after acceptance and is held until the cache takes it.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   req_valid  in   cache presents a request
//   req_ready  out  responder idle and able to accept
//   req_write  in   1 = write-back, 0 = line fill
//   req_addr   in   byte address; word index is req_addr[IDX_W+1:2], upper bits alias
//   req_wdata  in   write-back data
//   resp_valid out  response available
//   resp_ready in   cache accepts response
//   resp_rdata out  fill data (0 for writes and errors)
//   resp_write out  echoes the write flag of the completed request
//   resp_err   out  misaligned-address error
//   busy       out  a request is outstanding
module cache_mem_responder #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LATENCY   = 4,   // must be >= 1
  parameter int unsigned IDX_W     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_write,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_write_q, resp_write_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_we;

  // Backing array: zero at power-up and deliberately untouched by reset.
  logic [31:0] mem_q [MEM_DEPTH] = '{default: 32'h0};

  // Upper address bits only alias; they never select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:IDX_W+2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_write_d = resp_write_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          // Capture everything now; the cache may change its inputs after this edge.
          idx_d   = req_addr[IDX_W+1:2];
          wdata_d = req_wdata;
          write_d = req_write;
          err_d   = |req_addr[1:0];
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          // Access edge: write commits and read samples the array together with
          // the transition into StResp.
          mem_we       = write_q && !err_q;
          resp_valid_d = 1'b1;
          resp_write_d = write_q;
          resp_err_d   = err_q;
          resp_rdata_d = (write_q || err_q) ? 32'h0 : mem_q[idx_q];
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_write_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_write_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_write_q <= resp_write_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Gated by reset so an aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_write = resp_write_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
module tb_cache_mem_responder;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned LATENCY   = 4;
  localparam int unsigned IDX_W     = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_write;
  logic        resp_err;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  // Reference memory: plain word array indexed by (byte address / 4) mod depth.
  logic [31:0] ref_mem [MEM_DEPTH];

  cache_mem_responder #(
    .MEM_DEPTH(MEM_DEPTH),
    .LATENCY  (LATENCY),
    .IDX_W    (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_write(resp_write),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic bit model_err(logic [31:0] addr);
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr);
    return ref_mem[(addr / 4) % MEM_DEPTH];
  endfunction

  function automatic void model_apply(bit wr, logic [31:0] addr, logic [31:0] wdata);
    if (wr && !model_err(addr)) ref_mem[(addr / 4) % MEM_DEPTH] = wdata;
  endfunction

  // One full transaction. stall = cycles resp_ready is held low after resp_valid rises.
  // poke = drive a competing write request during the stall (must be ignored).
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall, input bit poke, input logic [31:0] exp_rdata,
                         input bit exp_err, input string tag);
    int waited;
    int lat;
    logic [31:0] held;
    @(negedge clk);
    resp_ready = (stall == 0);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk({tag, " accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance to prove they were captured.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = 1'($urandom);
    chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    chk({tag, " ready_low_after_accept"}, 32'(req_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < int'(LATENCY) + 20);
    chk({tag, " latency"}, 32'(lat), 32'(LATENCY));
    chk({tag, " rdata"}, resp_rdata, exp_rdata);
    chk({tag, " resp_write"}, 32'(resp_write), 32'(wr));
    chk({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
    held = resp_rdata;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_1000;
        req_wdata = 32'hFFFF_FFFF;
      end
      @(posedge clk);
      #1;
      chk({tag, " stall_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " stall_rdata"}, resp_rdata, held);
      chk({tag, " stall_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " valid_cleared"}, 32'(resp_valid), 32'd0);
    chk({tag, " ready_after_hs"}, 32'(req_ready), 32'd1);
    chk({tag, " busy_after_hs"}, 32'(busy), 32'd0);
  endtask

  task automatic model_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int stall, input string tag);
    logic [31:0] exp;
    exp = (wr || model_err(addr)) ? 32'h0 : model_read(addr);
    run_txn(wr, addr, wdata, stall, 1'b0, exp, model_err(addr), tag);
    model_apply(wr, addr, wdata);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    bit          saw_valid;
    bit          wr;
    logic [31:0] addr;
    int unsigned w;

    for (int i = 0; i < int'(MEM_DEPTH); i++) ref_mem[i] = 32'h0;

    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_1004, 32'hAAAA_0001, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_1004, 32'h0,         32'hAAAA_0001, 1'b0};
    vecs[3] = '{1'b1, 32'h1000_1000, 32'hBBBB_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_1000, 32'h0,         32'hBBBB_0000, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_1002, 32'h0,         32'h0000_0000, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_1000, 32'h0,         32'hBBBB_0000, 1'b0};
    vecs[8] = '{1'b0, 32'h2000_1004, 32'h0,         32'hAAAA_0001, 1'b0};

    // Reset held for two cycles.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset resp_write", 32'(resp_write), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 1'b0, vecs[i].exp_rdata,
              vecs[i].exp_err, $sformatf("vec%0d", i));
      model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    end

    // Backpressure with a competing request that must not be taken.
    run_txn(1'b0, 32'h0000_1004, 32'h0, 6, 1'b1, 32'hAAAA_0001, 1'b0, "bp");
    run_txn(1'b0, 32'h0000_1000, 32'h0, 0, 1'b0, 32'hBBBB_0000, 1'b0, "bp_no_poke_write");

    // Reset mid-operation.
    model_txn(1'b1, 32'h0000_0020, 32'h1111_0000, 0, "pre_reset_write");
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h0000_0020;
    req_wdata  = 32'h1234_5678;
    chk("midrst ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("midrst busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < int'(LATENCY) + 6; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) saw_valid = 1'b1;
    end
    chk("midrst no_response", 32'(saw_valid), 32'd0);
    chk("midrst ready", 32'(req_ready), 32'd1);
    chk("midrst busy_clear", 32'(busy), 32'd0);
    run_txn(1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, 32'h1111_0000, 1'b0, "midrst readback");
    run_txn(1'b0, 32'h0000_1004, 32'h0, 0, 1'b0, 32'hAAAA_0001, 1'b0, "midrst preserved");

    // Randomised traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom);
      w = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) w += 1016;
      addr = ($urandom << 12) | (32'(w) << 2);
      if ($urandom_range(0, 5) == 0) addr = addr | 32'($urandom_range(1, 3));
      model_txn(wr, addr, $urandom, $urandom_range(0, 3), $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
